// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory/serial bus arbiter.
//   state_e            : arbiter sequencer states
//   SERIAL_*_ADDR      : memory-mapped UART register addresses
//   IDLE_*             : values the bus outputs hold whenever no strobe is active
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_W_SETUP  = 3'd2,
    ST_W_PULSE  = 3'd3,
    ST_W_HOLD   = 3'd4,
    ST_SER_WAIT = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  localparam logic [31:0] SERIAL_STATE_ADDR = 32'hBFD003FC;
  localparam logic [31:0] SERIAL_DATA_ADDR  = 32'hBFD003F8;

  localparam logic [31:0] IDLE_ADDR  = 32'h0000_0000;
  localparam logic [31:0] IDLE_WDATA = 32'h0000_0000;
  localparam logic        IDLE_WE_N  = 1'b1;
  localparam logic [3:0]  IDLE_SEL_N = 4'hF;
  localparam logic        IDLE_CE    = 1'b0;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one memory/serial access port between the CPU fetch and data ports.
// Each access is sequenced into single-cycle chip-enable strobes so SRAM and
// the memory-mapped UART see exactly one read or one write per access.
//   clk, rst (async, active-low)
//   if_req/if_addr -> if_ack/if_rdata     : instruction fetch port
//   d_req/d_we/d_addr/d_wdata/d_sel_n
//                  -> d_ack/d_rdata       : data port (priority, burst limited)
//   mem_addr/mem_wdata/mem_we_n/mem_sel_n/mem_ce -> memory controller
//   mem_rdata                             : combinational read data
//   txd_busy                              : UART transmitter busy
module mem_bus_arbiter #(
  parameter int unsigned MAX_D_BURST      = 4,
  parameter logic [31:0] SERIAL_DATA_ADDR = mem_bus_arbiter_pkg::SERIAL_DATA_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel_n,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we_n,
  output logic [3:0]  mem_sel_n,
  output logic        mem_ce,
  input  logic [31:0] mem_rdata,
  input  logic        txd_busy
);
  import mem_bus_arbiter_pkg::*;

  localparam int BW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_D_BURST);

  state_e        state_q;
  logic          gnt_is_d_q;   // 1 = current access belongs to the data port
  logic          mask_if_q;    // port acked last cycle: its req is still stale
  logic          mask_d_q;
  logic [BW-1:0] burst_q;

  logic if_ok, d_ok, gnt_if, gnt_d, ser_stall;

  // Arbitration: data wins unless it has used up its burst while fetch waits.
  always_comb begin
    if_ok     = if_req & ~mask_if_q;
    d_ok      = d_req & ~mask_d_q;
    gnt_d     = 1'b0;
    gnt_if    = 1'b0;
    if (d_ok && (!if_ok || (burst_q != BURST_LIM))) begin
      gnt_d = 1'b1;
    end else if (if_ok) begin
      gnt_if = 1'b1;
    end
    ser_stall = d_we && (d_addr == SERIAL_DATA_ADDR) && txd_busy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gnt_is_d_q <= 1'b0;
      mask_if_q  <= 1'b0;
      mask_d_q   <= 1'b0;
      burst_q    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_addr   <= IDLE_ADDR;
      mem_wdata  <= IDLE_WDATA;
      mem_we_n   <= IDLE_WE_N;
      mem_sel_n  <= IDLE_SEL_N;
      mem_ce     <= IDLE_CE;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          mask_if_q <= 1'b0;
          mask_d_q  <= 1'b0;
          if (gnt_d) begin
            gnt_is_d_q <= 1'b1;
            if (!if_req) begin
              burst_q <= '0;
            end else if (burst_q != BURST_LIM) begin
              burst_q <= burst_q + BW'(1);
            end
            if (!d_we) begin
              state_q   <= ST_RD;
              mem_ce    <= 1'b1;
              mem_we_n  <= 1'b1;
              mem_addr  <= d_addr;
              mem_sel_n <= d_sel_n;
            end else if (ser_stall) begin
              state_q <= ST_SER_WAIT;
            end else begin
              state_q   <= ST_W_SETUP;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_sel_n <= d_sel_n;
            end
          end else if (gnt_if) begin
            gnt_is_d_q <= 1'b0;
            burst_q    <= '0;
            state_q    <= ST_RD;
            mem_ce     <= 1'b1;
            mem_we_n   <= 1'b1;
            mem_addr   <= if_addr;
            mem_sel_n  <= 4'h0;
          end
        end
        // Bus stays idle while the UART is busy; the held request is reloaded.
        ST_SER_WAIT: begin
          if (!txd_busy) begin
            state_q   <= ST_W_SETUP;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_sel_n <= d_sel_n;
          end
        end
        ST_W_SETUP: begin
          state_q  <= ST_W_PULSE;
          mem_ce   <= 1'b1;
          mem_we_n <= 1'b0;
        end
        // ce and we_n drop together so the strobe never looks like a read.
        ST_W_PULSE: begin
          state_q  <= ST_W_HOLD;
          mem_ce   <= 1'b0;
          mem_we_n <= 1'b1;
        end
        ST_W_HOLD: begin
          state_q   <= ST_DONE;
          d_ack     <= 1'b1;
          mem_addr  <= IDLE_ADDR;
          mem_wdata <= IDLE_WDATA;
          mem_sel_n <= IDLE_SEL_N;
        end
        ST_RD: begin
          state_q   <= ST_DONE;
          mem_ce    <= IDLE_CE;
          mem_we_n  <= IDLE_WE_N;
          mem_addr  <= IDLE_ADDR;
          mem_sel_n <= IDLE_SEL_N;
          if (gnt_is_d_q) begin
            d_rdata <= mem_rdata;
            d_ack   <= 1'b1;
          end else begin
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          mask_d_q  <= gnt_is_d_q;
          mask_if_q <= ~gnt_is_d_q;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_ce    <= IDLE_CE;
          mem_we_n  <= IDLE_WE_N;
          mem_addr  <= IDLE_ADDR;
          mem_wdata <= IDLE_WDATA;
          mem_sel_n <= IDLE_SEL_N;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam logic [31:0] UART_DATA = 32'hBFD003F8;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_sel_n = 4'hF;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we_n, mem_ce;
  logic [3:0]  mem_sel_n;
  logic        txd_busy = 1'b0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Memory contents as seen by the bench: a few fixed words, otherwise a hash.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h3C01_1234;
    if (a == UART_DATA)     return 32'h0000_00C3;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  assign mem_rdata = memf(mem_addr);

  mem_bus_arbiter #(.MAX_D_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sel_n(d_sel_n), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we_n(mem_we_n),
    .mem_sel_n(mem_sel_n), .mem_ce(mem_ce), .mem_rdata(mem_rdata),
    .txd_busy(txd_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: plan of per-cycle bus steps ----------------
  localparam int K_ARB = 0, K_BUS = 1, K_WAIT = 2;

  typedef struct {
    int          kind;
    logic        ce, we_n;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic        ia, da;
    int          mask;       // 0 none, 1 fetch, 2 data
    logic        ui, ud;
    logic [31:0] rd;
  } step_t;

  step_t       cur;
  step_t       plan[$];
  logic [31:0] m_if_rdata = '0, m_d_rdata = '0;
  int          m_burst = 0;
  bit          iv, dv;

  function automatic step_t st(int kind, logic ce, logic we_n, logic [31:0] a,
                               logic [31:0] w, logic [3:0] s, logic ia, logic da,
                               int mask, logic ui, logic ud, logic [31:0] rd);
    step_t r;
    r.kind = kind; r.ce = ce; r.we_n = we_n; r.addr = a; r.wdata = w; r.sel = s;
    r.ia = ia; r.da = da; r.mask = mask; r.ui = ui; r.ud = ud; r.rd = rd;
    return r;
  endfunction

  function automatic step_t idle_step(int kind, int mask);
    return st(kind, 1'b0, 1'b1, '0, '0, 4'hF, 1'b0, 1'b0, mask, 1'b0, 1'b0, '0);
  endfunction

  task automatic plan_read(input bit is_d, input logic [31:0] a, input logic [3:0] s);
    plan.push_back(st(K_BUS, 1'b1, 1'b1, a, '0, s, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0));
    plan.push_back(st(K_BUS, 1'b0, 1'b1, '0, '0, 4'hF, !is_d, is_d, 0, !is_d, is_d, memf(a)));
    plan.push_back(idle_step(K_ARB, is_d ? 2 : 1));
  endtask

  task automatic plan_write(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    plan.push_back(st(K_BUS, 1'b0, 1'b1, a, w, s, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0));
    plan.push_back(st(K_BUS, 1'b1, 1'b0, a, w, s, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0));
    plan.push_back(st(K_BUS, 1'b0, 1'b1, a, w, s, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0));
    plan.push_back(st(K_BUS, 1'b0, 1'b1, '0, '0, 4'hF, 1'b0, 1'b1, 0, 1'b0, 1'b0, '0));
    plan.push_back(idle_step(K_ARB, 2));
  endtask

  initial cur = idle_step(K_ARB, 0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      plan.delete();
      cur = idle_step(K_ARB, 0);
      m_if_rdata = '0;
      m_d_rdata = '0;
      m_burst = 0;
    end else begin
      if (cur.kind == K_ARB) begin
        iv = if_req && (cur.mask != 1);
        dv = d_req && (cur.mask != 2);
        if (dv && !(iv && m_burst == MAXB)) begin
          m_burst = if_req ? ((m_burst < MAXB) ? m_burst + 1 : m_burst) : 0;
          if (!d_we) plan_read(1'b1, d_addr, d_sel_n);
          else if (d_addr == UART_DATA && txd_busy) plan.push_back(idle_step(K_WAIT, 0));
          else plan_write(d_addr, d_wdata, d_sel_n);
        end else if (iv) begin
          m_burst = 0;
          plan_read(1'b0, if_addr, 4'h0);
        end
        if (plan.size() > 0) cur = plan.pop_front();
        else cur = idle_step(K_ARB, 0);
      end else if (cur.kind == K_WAIT) begin
        if (!txd_busy) begin
          plan_write(d_addr, d_wdata, d_sel_n);
          cur = plan.pop_front();
        end
      end else begin
        cur = plan.pop_front();
      end
      if (cur.ui) m_if_rdata = cur.rd;
      if (cur.ud) m_d_rdata = cur.rd;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  logic [135:0] ev, av;
  always @(negedge clk) begin
    if (chk_en) begin
      ev = {cur.ce, cur.we_n, cur.sel, cur.addr, cur.wdata, cur.ia, cur.da, m_if_rdata, m_d_rdata};
      av = {mem_ce, mem_we_n, mem_sel_n, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL cycle t=%0t: got %h expected %h", $time, av, ev);
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          busy;   // cycles txd_busy stays high from the request cycle
    int          lat;    // cycle of the ack, request cycle = 0
    bit          chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    int k, ces, bad;
    bit got;
    @(negedge clk);
    txd_busy = (v.busy > 0);
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_sel_n = v.sel;
    end
    k = 0; ces = 0; bad = 0; got = 1'b0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      if (mem_ce) ces++;
      if (mem_ce && mem_we_n && v.we) bad++;
      if ((v.fetch && if_ack) || (!v.fetch && d_ack)) got = 1'b1;
      if (k == v.busy) txd_busy = 1'b0;
    end
    chk($sformatf("v%0d ack cycle", idx), k, v.lat);
    chk($sformatf("v%0d ce pulses", idx), ces, 1);
    if (v.we) chk($sformatf("v%0d ce with we_n high", idx), bad, 0);
    if (v.chk_rd) chk($sformatf("v%0d rdata", idx), v.fetch ? if_rdata : d_rdata, v.rd);
    if_req = 1'b0; d_req = 1'b0; txd_busy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return UART_DATA;
    return 32'h8000_0000 + ({$urandom_range(0, 255)} << 2);
  endfunction

  int k, dk, dk2, ik;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 2, 1'b1, 32'h3C01_1234};
    vecs[1] = '{1'b0, 1'b0, 32'h8040_0010, 32'h0, 4'h0, 0, 2, 1'b1, 32'h25E5_5A4A};
    vecs[2] = '{1'b0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1110, 0, 4, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, UART_DATA, 32'h0000_0041, 4'b1110, 10, 14, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, UART_DATA, 32'h0, 4'b1110, 0, 2, 1'b1, 32'h0000_00C3};
    vecs[5] = '{1'b0, 1'b1, UART_DATA, 32'h0000_0042, 4'b1110, 0, 4, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, 2, 1'b1, 32'h25A5_5A4A};
    vecs[7] = '{1'b0, 1'b1, 32'h8000_0008, 32'h1234_5678, 4'b0011, 3, 4, 1'b0, 32'h0};

    // reset state
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset mem_ce", {31'b0, mem_ce}, 32'h0);
    chk("reset mem_we_n", {31'b0, mem_we_n}, 32'h1);
    chk("reset mem_sel_n", {28'b0, mem_sel_n}, 32'hF);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset acks", {30'b0, if_ack, d_ack}, 32'h0);
    chk("reset rdata", if_rdata | d_rdata, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // simultaneous requests, data port keeps requesting
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8000_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8040_0010; d_sel_n = 4'h0;
    k = 0; dk = -1; dk2 = -1; ik = -1;
    while (dk2 < 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (d_ack) begin
        if (dk < 0) dk = k;
        else begin dk2 = k; d_req = 1'b0; end
      end
      if (if_ack) begin ik = k; if_req = 1'b0; end
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("both: first d_ack cycle", dk, 2);
    chk("both: if_ack cycle", ik, 5);
    chk("both: second d_ack cycle", dk2, 8);
    chk("both: if_rdata", if_rdata, 32'h3C01_1234);
    repeat (2) @(negedge clk);

    // reset during the write strobe
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0004; d_wdata = 32'hCAFE_F00D; d_sel_n = 4'h0;
    k = 0;
    while (!mem_ce && k < 10) begin @(negedge clk); k++; end
    chk("rst: reached W_PULSE", k, 2);
    #2 rst = 1'b0;
    #1;
    chk("rst: mem_ce immediate", {31'b0, mem_ce}, 32'h0);
    chk("rst: mem_we_n immediate", {31'b0, mem_we_n}, 32'h1);
    chk("rst: mem_addr immediate", mem_addr, 32'h0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dk = 0;
    repeat (6) begin @(negedge clk); if (d_ack) dk++; end
    chk("rst: no d_ack after abort", dk, 0);
    run_vec(8, vecs[2]);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (if_req && if_ack) begin
        if_req = $urandom_range(0, 1);
        if_addr = 32'h8000_0000 + ({$urandom_range(0, 255)} << 2);
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1;
        if_addr = 32'h8000_0000 + ({$urandom_range(0, 255)} << 2);
      end
      if ((d_req && d_ack) || (!d_req && $urandom_range(0, 2) == 0)) begin
        d_req = $urandom_range(0, 1);
        d_we = $urandom_range(0, 1);
        d_addr = rnd_addr();
        d_wdata = $urandom;
        d_sel_n = $urandom_range(0, 15);
      end
      if ($urandom_range(0, 7) == 0) txd_busy = ~txd_busy;
    end
    txd_busy = 1'b0;
    k = 0;
    while ((if_req || d_req) && k < 100) begin
      @(negedge clk);
      k++;
      if (if_ack) if_req = 1'b0;
      if (d_ack) d_req = 1'b0;
    end
    chk("random: drained", {31'b0, if_req | d_req}, 32'h0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
